// File: rtl/tick_pkg.sv
// Shared definitions for the tick period meter slice.
//   - FSM state encoding (IDLE, MEASURE)
//   - default parameter values
//   - result-width helper, used by the meter and by its result interface
package tick_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MAX_COUNT   = 255;

  // Number of bits needed to hold max_count exactly.
  function automatic int period_cw(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/tick_period_meter_if.sv
// Result channel of the tick period meter (valid/ready).
//   period_out   measured period in clk cycles
//   period_ovf   qualifies period_out: the true gap exceeded the maximum count
//   period_valid result held until accepted
//   period_ready consumer accepts when valid & ready at a clk edge
//   missed       one-cycle pulse: an unaccepted result was overwritten
// master = meter (producer), slave = consumer.
interface tick_period_meter_if
  import tick_pkg::*;
#(
  parameter int CW = period_cw(DEF_MAX_COUNT)
) ();

  logic [CW-1:0] period_out;
  logic          period_ovf;
  logic          period_valid;
  logic          period_ready;
  logic          missed;

  modport master (
    output period_out,
    output period_ovf,
    output period_valid,
    output missed,
    input  period_ready
  );

  modport slave (
    input  period_out,
    input  period_ovf,
    input  period_valid,
    input  missed,
    output period_ready
  );

endinterface

// File: rtl/tick_period_meter_sync_edge_det.sv
// Synchronizer and rising-edge detector for an asynchronous tick line.
//   clk      in  clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   event_i  in  raw tick line, asynchronous to clk
//   edge_o   out one-cycle pulse per rising edge seen at the synchronizer output
// A level held high yields exactly one pulse.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic event_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], event_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tick_period_meter.sv
// Tick period meter: counts clk cycles between consecutive rising edges of an
// external tick line and reports each period on a valid/ready channel.
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   enable    in   measurement enable; low aborts the period in progress
//   event_in  in   tick line, asynchronous to clk
//   prd       master side of tick_period_meter_if (period_out, period_ovf,
//             period_valid, missed out; period_ready in)
// Periods longer than MAX_COUNT report MAX_COUNT with period_ovf set.
module tick_period_meter
  import tick_pkg::*;
#(
  parameter int MAX_COUNT   = DEF_MAX_COUNT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                event_in,
  tick_period_meter_if.master prd
);

  localparam int            CW    = period_cw(MAX_COUNT);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

  // Saturating increment in CW bits: compares before adding, never wraps.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAX_C) ? MAX_C : v + CW'(1);
  endfunction

  logic evt_edge;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk     (clk),
    .reset_n (reset_n),
    .event_i (event_in),
    .edge_o  (evt_edge)
  );

  // ---- measurement FSM and counter ----
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          new_res;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    new_res = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        ovf_d = 1'b0;
        // The first edge only opens a period; it has nothing to report.
        if (evt_edge && enable) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (evt_edge) begin
          new_res = 1'b1;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          cnt_d = sat_inc(cnt_q);
          // Once the counter sits at MAX_COUNT, counter+1 at the next edge
          // would exceed MAX_COUNT, so the flag is set on reaching it.
          ovf_d = (sat_inc(cnt_q) == MAX_C);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---- output register / handshake ----
  logic [CW-1:0] out_q, out_d;
  logic          oovf_q, oovf_d;
  logic          valid_q, valid_d;
  logic          missed_q, missed_d;

  always_comb begin
    out_d    = out_q;
    oovf_d   = oovf_q;
    valid_d  = valid_q;
    missed_d = 1'b0;
    if (new_res) begin
      // Result at the edge is counter+1, capped at MAX_COUNT.
      out_d    = sat_inc(cnt_q);
      oovf_d   = ovf_q;
      valid_d  = 1'b1;
      missed_d = valid_q & ~prd.period_ready;
    end else if (valid_q && prd.period_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q    <= '0;
      oovf_q   <= 1'b0;
      valid_q  <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      oovf_q   <= oovf_d;
      valid_q  <= valid_d;
      missed_q <= missed_d;
    end
  end

  assign prd.period_out   = out_q;
  assign prd.period_ovf   = oovf_q;
  assign prd.period_valid = valid_q;
  assign prd.missed       = missed_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Testbench for tick_period_meter: directed scenarios plus randomized ticks,
// enable and ready, checked every cycle against a timestamp-based model.
module tb_tick_period_meter;
  import tick_pkg::*;

  localparam int MAXC = 255;
  localparam int S    = 2;
  localparam int CW   = period_cw(MAXC);

  logic clk;
  logic reset_n;
  logic enable;
  logic event_in;

  tick_period_meter_if #(.CW(CW)) pif ();

  tick_period_meter #(
    .MAX_COUNT   (MAXC),
    .SYNC_STAGES (S)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .event_in (event_in),
    .prd      (pif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model state: detection timestamps and the start of the open period.
  int detq[$];
  int anchor   = -1;
  bit prev_ev  = 1'b0;
  bit m_valid  = 1'b0;
  bit m_ovf    = 1'b0;
  bit m_missed = 1'b0;
  int m_out    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    detq.delete();
    anchor   = -1;
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
    m_missed = 1'b0;
    m_out    = 0;
  endfunction

  // One clock edge p: a tick is measured from its detection time; a period is
  // the difference of two detection times inside one uninterrupted enable run.
  function automatic void model_clock(input int p, input bit en, input bit rdy);
    bit det;
    bit emit;
    int per;
    det  = 1'b0;
    emit = 1'b0;
    per  = 0;
    while (detq.size() > 0 && detq[0] < p) void'(detq.pop_front());
    if (detq.size() > 0 && detq[0] == p) begin
      det = 1'b1;
      void'(detq.pop_front());
    end
    if (!en) anchor = -1;
    else if (det) begin
      if (anchor >= 0) begin
        per  = p - anchor;
        emit = 1'b1;
      end
      anchor = p;
    end
    if (emit) begin
      m_missed = m_valid && !rdy;
      m_valid  = 1'b1;
      m_out    = (per > MAXC) ? MAXC : per;
      m_ovf    = (per > MAXC);
    end else begin
      m_missed = 1'b0;
      if (m_valid && rdy) m_valid = 1'b0;
    end
  endfunction

  task automatic compare_all();
    check_eq("valid",  32'(pif.period_valid), 32'(m_valid));
    check_eq("missed", 32'(pif.missed),       32'(m_missed));
    check_eq("out",    32'(pif.period_out),   32'(m_out));
    check_eq("ovf",    32'(pif.period_ovf),   32'(m_ovf));
  endtask

  // Drive inputs for the next edge, take the edge, update model, compare.
  task automatic step(input bit ev, input bit en, input bit rdy);
    // Line first sampled at edge cyc+1, edge pulse acted on at cyc+S+1.
    if (ev && !prev_ev) detq.push_back(cyc + S + 1);
    prev_ev          = ev;
    event_in         = ev;
    enable           = en;
    pif.period_ready = rdy;
    @(posedge clk);
    cyc++;
    model_clock(cyc, en, rdy);
    #1;
    compare_all();
  endtask

  // One-cycle tick, then gap-1 low cycles. Checks the result of the period
  // ending at this tick exactly S+1 edges after the tick was driven.
  task automatic tick_chk(input int gap, input bit rdy, input bit exp_v, input int exp_out,
                          input bit exp_ovf, input bit exp_missed, input string tag);
    step(1'b1, 1'b1, rdy);
    for (int i = 0; i < S - 1; i++) step(1'b0, 1'b1, rdy);
    if (rdy) check_eq({tag, "_early"}, 32'(pif.period_valid), 32'd0);
    step(1'b0, 1'b1, rdy);
    check_eq({tag, "_v"}, 32'(pif.period_valid), 32'(exp_v));
    check_eq({tag, "_missed"}, 32'(pif.missed), 32'(exp_missed));
    if (exp_v) begin
      check_eq({tag, "_out"}, 32'(pif.period_out), 32'(exp_out));
      check_eq({tag, "_ovf"}, 32'(pif.period_ovf), 32'(exp_ovf));
    end
    for (int i = S + 1; i < gap; i++) step(1'b0, 1'b1, rdy);
  endtask

  initial begin
    int g;
    int w;
    int pos;
    int en_low;

    reset_n          = 1'b0;
    enable           = 1'b0;
    event_in         = 1'b0;
    pif.period_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid",  32'(pif.period_valid), 32'd0);
    check_eq("rst_out",    32'(pif.period_out),   32'd0);
    check_eq("rst_ovf",    32'(pif.period_ovf),   32'd0);
    check_eq("rst_missed", 32'(pif.missed),       32'd0);
    reset_n = 1'b1;

    // Regular 100-cycle ticks, then a saturating gap and a short one.
    tick_chk(100, 1'b1, 1'b0, 0,   1'b0, 1'b0, "first");
    tick_chk(100, 1'b1, 1'b1, 100, 1'b0, 1'b0, "p100a");
    tick_chk(300, 1'b1, 1'b1, 100, 1'b0, 1'b0, "p100b");
    tick_chk(50,  1'b1, 1'b1, 255, 1'b1, 1'b0, "gap300");
    tick_chk(20,  1'b0, 1'b1, 50,  1'b0, 1'b0, "gap50");

    // Backpressure: results every 20 cycles overwrite the held one.
    tick_chk(20, 1'b0, 1'b1, 20, 1'b0, 1'b1, "ovr1");
    tick_chk(30, 1'b0, 1'b1, 20, 1'b0, 1'b1, "ovr2");

    // New result lands on the same edge as an accept: no miss, new value.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check_eq("coinc_v",      32'(pif.period_valid), 32'd1);
    check_eq("coinc_out",    32'(pif.period_out),   32'd30);
    check_eq("coinc_missed", 32'(pif.missed),       32'd0);
    step(1'b0, 1'b1, 1'b1);
    check_eq("accept_drop", 32'(pif.period_valid), 32'd0);

    // Enable low for 10 cycles mid-period.
    for (int i = 0; i < 26; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
    tick_chk(40, 1'b1, 1'b0, 0,  1'b0, 1'b0, "en_first");
    tick_chk(40, 1'b0, 1'b1, 40, 1'b0, 1'b0, "en_next");

    // Asynchronous reset mid-period while a result is pending.
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_valid",  32'(pif.period_valid), 32'd0);
    check_eq("arst_out",    32'(pif.period_out),   32'd0);
    check_eq("arst_ovf",    32'(pif.period_ovf),   32'd0);
    check_eq("arst_missed", 32'(pif.missed),       32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Level held high 40 cycles is one tick; next tick 60 cycles after it.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
    tick_chk(50, 1'b1, 1'b1, 60, 1'b0, 1'b0, "hold");

    // Randomized ticks, enable drop-outs and ready.
    pos    = 0;
    en_low = 0;
    g      = $urandom_range(2, 40);
    w      = $urandom_range(1, g - 1);
    for (int k = 0; k < 4000; k++) begin
      bit ev;
      bit en;
      bit rdy;
      ev = (pos < w);
      if (en_low > 0) begin
        en = 1'b0;
        en_low--;
      end else begin
        en = 1'b1;
        if ($urandom_range(0, 199) == 0) en_low = $urandom_range(1, 20);
      end
      rdy = ($urandom_range(0, 3) != 0);
      step(ev, en, rdy);
      pos++;
      if (pos >= g) begin
        pos = 0;
        case ($urandom_range(0, 19))
          0:       g = $urandom_range(254, 256);
          1, 2:    g = $urandom_range(200, 400);
          default: g = $urandom_range(2, 40);
        endcase
        w = $urandom_range(1, g - 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
